// File: rtl/riscv_alu_pkg.sv
// Shared RV32I integer ALU definitions: opcode/funct encodings, request bundle
// and ALU status codes used by alu and alu_arbiter.
package riscv_alu_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef struct packed {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
    } alu_req_t;

    typedef enum logic {
        ALU_OK      = 1'b0,
        ALU_ILLEGAL = 1'b1
    } alu_status_e;

endpackage

// File: rtl/alu.sv
// Combinational RV32I integer ALU for OP and OP-IMM; unsupported encodings
// produce a zero result and flag ALU_ILLEGAL on status.
module alu
    import riscv_alu_pkg::*;
(
    input  alu_req_t    req,
    output logic [31:0] result,
    output logic        zero,
    output alu_status_e status
);

    logic        is_op;
    logic        f7_base;
    logic        f7_alt;
    logic        f7_ok;
    logic        legal;
    logic [4:0]  shamt;
    logic [31:0] raw;

    assign is_op   = (req.opcode == OPC_OP);
    assign f7_base = (req.funct7 == F7_BASE);
    assign f7_alt  = (req.funct7 == F7_ALT);
    // For OP-IMM non-shift ops the funct7 bits are part of the immediate.
    assign f7_ok   = !is_op || f7_base;
    assign shamt   = req.op2[4:0];

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        raw   = '0;
        legal = is_op || (req.opcode == OPC_OP_IMM);
        case (req.funct3)
            F3_ADD:  if (is_op && f7_alt) raw = req.op1 - req.op2;
                     else if (f7_ok)      raw = req.op1 + req.op2;
                     else                 legal = 1'b0;
            F3_SLL:  if (f7_base) raw = req.op1 << shamt;
                     else         legal = 1'b0;
            F3_SLT:  if (f7_ok) raw = {31'b0, $signed(req.op1) < $signed(req.op2)};
                     else       legal = 1'b0;
            F3_SLTU: if (f7_ok) raw = {31'b0, req.op1 < req.op2};
                     else       legal = 1'b0;
            F3_XOR:  if (f7_ok) raw = req.op1 ^ req.op2;
                     else       legal = 1'b0;
            F3_SR:   if (f7_base)     raw = req.op1 >> shamt;
                     else if (f7_alt) raw = $unsigned($signed(req.op1) >>> shamt);
                     else             legal = 1'b0;
            F3_OR:   if (f7_ok) raw = req.op1 | req.op2;
                     else       legal = 1'b0;
            F3_AND:  if (f7_ok) raw = req.op1 & req.op2;
                     else       legal = 1'b0;
            default: legal = 1'b0;
        endcase
    end

    assign result = legal ? raw : '0;
    assign zero   = (result == '0);
    assign status = legal ? ALU_OK : ALU_ILLEGAL;

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first request at or above rr_ptr,
// wrapping at N; the pointer moves past the winner on every grant.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             en,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    localparam int unsigned NU = N;

    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] idx;
    logic             found;

    // Explicit wrap keeps non-power-of-2 N inside 0..N-1.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                  input int unsigned offs);
        int unsigned s;
        s = 32'(base) + offs;
        if (s >= NU) s = s - NU;
        return IDX_W'(s);
    endfunction

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = '0;
        for (int i = 0; i < N; i++) begin
            idx = wrap_add(rr_ptr, 32'(i));
            if (en && !found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n)     rr_ptr <= '0;
        else if (found) rr_ptr <= wrap_add(gnt_idx, 32'd1);
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one alu among NUM_CORES requesters: round-robin grant into an operand
// capture stage, then an ALU result register with a valid/ready response.
module alu_arbiter
    import riscv_alu_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int ID_W      = $clog2(NUM_CORES)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_CORES-1:0]   req_valid,
    output logic [NUM_CORES-1:0]   req_ready,
    input  logic [NUM_CORES*32-1:0] req_op1,
    input  logic [NUM_CORES*32-1:0] req_op2,
    input  logic [NUM_CORES*7-1:0] req_opcode,
    input  logic [NUM_CORES*3-1:0] req_funct3,
    input  logic [NUM_CORES*7-1:0] req_funct7,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [ID_W-1:0]        resp_id,
    output logic [31:0]            resp_result,
    output logic                   resp_zero
);

    logic                 s1_valid;
    logic [ID_W-1:0]      s1_id;
    alu_req_t             s1_req;
    alu_req_t             sel_req;
    logic                 s2_free;
    logic                 s1_free;
    logic                 grant;
    logic [NUM_CORES-1:0] gnt;
    logic [ID_W-1:0]      gnt_idx;
    logic [31:0]          alu_result;
    logic                 alu_zero;
    alu_status_e          unused_status;

    assign s2_free = !resp_valid || resp_ready;
    assign s1_free = !s1_valid || s2_free;

    // Gating with rst_n keeps req_ready low for the whole reset pulse.
    rr_arbiter #(
        .N     (NUM_CORES),
        .IDX_W (ID_W)
    ) u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (req_valid),
        .en      (s1_free && rst_n),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req_ready = gnt;
    assign grant     = |gnt;

    always_comb begin
        sel_req.op1    = req_op1[32*int'(gnt_idx) +: 32];
        sel_req.op2    = req_op2[32*int'(gnt_idx) +: 32];
        sel_req.opcode = req_opcode[7*int'(gnt_idx) +: 7];
        sel_req.funct3 = req_funct3[3*int'(gnt_idx) +: 3];
        sel_req.funct7 = req_funct7[7*int'(gnt_idx) +: 7];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       s1_valid <= 1'b0;
        else if (grant)   s1_valid <= 1'b1;
        else if (s2_free) s1_valid <= 1'b0;
    end

    // NOTE: the S1 payload is qualified by s1_valid, so it needs no reset and stays a plain flop bank.
    always_ff @(posedge clk) begin
        if (grant) begin
            s1_id  <= gnt_idx;
            s1_req <= sel_req;
        end
    end

    alu u_alu (
        .req    (s1_req),
        .result (alu_result),
        .zero   (alu_zero),
        .status (unused_status)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid  <= 1'b0;
            resp_id     <= '0;
            resp_result <= '0;
            resp_zero   <= 1'b0;
        end else if (s1_valid && s2_free) begin
            resp_valid  <= 1'b1;
            resp_id     <= s1_id;
            resp_result <= alu_result;
            resp_zero   <= alu_zero;
        end else if (resp_ready) begin
            resp_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed-vector bench for alu_arbiter: grant order, pipeline latency,
// backpressure, illegal ops, asynchronous reset and pointer wrap.
module tb_alu_arbiter;
    import riscv_alu_pkg::*;

    localparam int NC = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NC-1:0]   req_valid;
    logic [NC-1:0]   req_ready;
    logic [NC*32-1:0] req_op1;
    logic [NC*32-1:0] req_op2;
    logic [NC*7-1:0] req_opcode;
    logic [NC*3-1:0] req_funct3;
    logic [NC*7-1:0] req_funct7;
    logic            resp_valid;
    logic            resp_ready;
    logic [1:0]      resp_id;
    logic [31:0]     resp_result;
    logic            resp_zero;

    int vecs = 0;
    int errs = 0;

    localparam logic [31:0] A_TAB [9] = '{32'h1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hF0, 32'h80000000,
                                          32'h0F00, 32'hFF00FF00, 32'h10, 32'd6};
    localparam logic [31:0] B_TAB [9] = '{32'h4, 32'h0, 32'h1, 32'hFF, 32'h4,
                                          32'h00F0, 32'h0FF00FF0, 32'h400, 32'd7};
    localparam logic [6:0]  O_TAB [9] = '{OPC_OP, OPC_OP, OPC_OP, OPC_OP, OPC_OP,
                                          OPC_OP, OPC_OP, OPC_OP_IMM, OPC_OP};
    localparam logic [2:0]  F3_TAB [9] = '{F3_SLL, F3_SLT, F3_SLTU, F3_XOR, F3_SR,
                                           F3_OR, F3_AND, F3_ADD, F3_ADD};
    localparam logic [6:0]  F7_TAB [9] = '{7'h00, 7'h00, 7'h00, 7'h00, 7'h00,
                                           7'h00, 7'h00, 7'h20, 7'h01};
    localparam logic [31:0] R_TAB [9] = '{32'd16, 32'd1, 32'd0, 32'h0F, 32'h08000000,
                                          32'h0FF0, 32'h0F000F00, 32'h410, 32'd0};

    alu_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op1     (req_op1),
        .req_op2     (req_op2),
        .req_opcode  (req_opcode),
        .req_funct3  (req_funct3),
        .req_funct7  (req_funct7),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .resp_zero   (resp_zero)
    );

    always #5 clk = ~clk;

    function automatic logic [35:0] rsp(input logic v, input logic [1:0] id,
                                        input logic [31:0] r, input logic z);
        return {v, id, r, z};
    endfunction

    function automatic logic [35:0] rsp_now();
        return {resp_valid, resp_id, resp_result, resp_zero};
    endfunction

    task automatic set_req(input int c, input logic [31:0] a, input logic [31:0] b,
                           input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7);
        req_op1[c*32 +: 32]   = a;
        req_op2[c*32 +: 32]   = b;
        req_opcode[c*7 +: 7]  = opc;
        req_funct3[c*3 +: 3]  = f3;
        req_funct7[c*7 +: 7]  = f7;
        req_valid[c]          = 1'b1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        req_valid  = '0;
        resp_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        req_valid  = '1;
        resp_ready = 1'b1;
        req_op1 = '0; req_op2 = '0; req_opcode = '0; req_funct3 = '0; req_funct7 = '0;
        #2;
        vecs++; if (req_ready !== 4'b0000) begin errs++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
        vecs++; if (rsp_now() !== rsp(1'b0, 2'd0, 32'd0, 1'b0)) begin errs++; $display("FAIL reset_resp: got %h want %h", rsp_now(), rsp(1'b0, 2'd0, 32'd0, 1'b0)); end
        @(negedge clk);
        req_valid = '0;
        rst_n     = 1'b1;
        #1;
        vecs++; if (resp_valid !== 1'b0) begin errs++; $display("FAIL reset_release: resp_valid got %b want 0", resp_valid); end
    endtask

    task automatic test_single();
        @(negedge clk);
        set_req(2, 32'd5, 32'd7, OPC_OP, F3_ADD, F7_BASE);
        resp_ready = 1'b1;
        #1;
        vecs++; if (req_ready !== 4'b0100) begin errs++; $display("FAIL single_gnt: got %b want 0100", req_ready); end
        @(negedge clk);
        req_valid = '0;
        #1;
        vecs++; if (resp_valid !== 1'b0) begin errs++; $display("FAIL single_s1: resp_valid got %b want 0", resp_valid); end
        @(negedge clk); #1;
        vecs++; if (rsp_now() !== rsp(1'b1, 2'd2, 32'd12, 1'b0)) begin errs++; $display("FAIL single_resp: got %h want %h", rsp_now(), rsp(1'b1, 2'd2, 32'd12, 1'b0)); end
        @(negedge clk); #1;
        vecs++; if (resp_valid !== 1'b0) begin errs++; $display("FAIL single_drain: resp_valid got %b want 0", resp_valid); end
    endtask

    task automatic test_all_sub();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0)
                for (int c = 0; c < NC; c++) set_req(c, 32'd9, 32'd9, OPC_OP, F3_ADD, F7_ALT);
            if (k == 5) req_valid = '0;
            #1;
            if (k < 5) begin
                vecs++; if (req_ready !== 4'(1 << (k % 4))) begin errs++; $display("FAIL rr_gnt[%0d]: got %b want %b", k, req_ready, 4'(1 << (k % 4))); end
            end
            if (k >= 2 && k < 7) begin
                vecs++; if (rsp_now() !== rsp(1'b1, 2'((k - 2) % 4), 32'd0, 1'b1)) begin errs++; $display("FAIL rr_resp[%0d]: got %h want %h", k, rsp_now(), rsp(1'b1, 2'((k - 2) % 4), 32'd0, 1'b1)); end
            end
            if (k == 7) begin
                vecs++; if (resp_valid !== 1'b0) begin errs++; $display("FAIL rr_drain: resp_valid got %b want 0", resp_valid); end
            end
        end
    endtask

    task automatic test_backpressure();
        @(negedge clk);
        set_req(1, 32'h80000000, 32'd4, OPC_OP, F3_SR, F7_ALT);
        set_req(2, 32'd1, 32'd2, OPC_OP, F3_ADD, F7_BASE);
        resp_ready = 1'b0;
        #1;
        vecs++; if (req_ready !== 4'b0010) begin errs++; $display("FAIL bp_gnt1: got %b want 0010", req_ready); end
        @(negedge clk);
        req_valid[1] = 1'b0;
        #1;
        vecs++; if (req_ready !== 4'b0100) begin errs++; $display("FAIL bp_gnt2: got %b want 0100", req_ready); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (k == 0) begin
                req_valid[2] = 1'b0;
                set_req(3, 32'd10, 32'd20, OPC_OP, F3_ADD, F7_BASE);
            end
            #1;
            vecs++; if (rsp_now() !== rsp(1'b1, 2'd1, 32'hF8000000, 1'b0)) begin errs++; $display("FAIL bp_hold[%0d]: got %h want %h", k, rsp_now(), rsp(1'b1, 2'd1, 32'hF8000000, 1'b0)); end
            vecs++; if (req_ready !== 4'b0000) begin errs++; $display("FAIL bp_stall[%0d]: req_ready got %b want 0000", k, req_ready); end
        end
        @(negedge clk);
        resp_ready = 1'b1;
        #1;
        vecs++; if (rsp_now() !== rsp(1'b1, 2'd1, 32'hF8000000, 1'b0)) begin errs++; $display("FAIL bp_release: got %h want %h", rsp_now(), rsp(1'b1, 2'd1, 32'hF8000000, 1'b0)); end
        vecs++; if (req_ready !== 4'b1000) begin errs++; $display("FAIL bp_gnt3: got %b want 1000", req_ready); end
        @(negedge clk);
        req_valid[3] = 1'b0;
        #1;
        vecs++; if (rsp_now() !== rsp(1'b1, 2'd2, 32'd3, 1'b0)) begin errs++; $display("FAIL bp_drain2: got %h want %h", rsp_now(), rsp(1'b1, 2'd2, 32'd3, 1'b0)); end
        @(negedge clk); #1;
        vecs++; if (rsp_now() !== rsp(1'b1, 2'd3, 32'd30, 1'b0)) begin errs++; $display("FAIL bp_drain3: got %h want %h", rsp_now(), rsp(1'b1, 2'd3, 32'd30, 1'b0)); end
        @(negedge clk); #1;
        vecs++; if (resp_valid !== 1'b0) begin errs++; $display("FAIL bp_empty: resp_valid got %b want 0", resp_valid); end
    endtask

    task automatic test_unknown_opcode();
        @(negedge clk);
        set_req(0, 32'd3, 32'd4, 7'h7F, 3'd0, 7'h00);
        resp_ready = 1'b1;
        #1;
        vecs++; if (req_ready !== 4'b0001) begin errs++; $display("FAIL unk_gnt: got %b want 0001", req_ready); end
        @(negedge clk);
        req_valid = '0;
        @(negedge clk); #1;
        vecs++; if (rsp_now() !== rsp(1'b1, 2'd0, 32'd0, 1'b1)) begin errs++; $display("FAIL unk_resp: got %h want %h", rsp_now(), rsp(1'b1, 2'd0, 32'd0, 1'b1)); end
        @(negedge clk); #1;
        vecs++; if (resp_valid !== 1'b0) begin errs++; $display("FAIL unk_drain: resp_valid got %b want 0", resp_valid); end
    endtask

    task automatic test_alu_ops();
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k < 9) set_req(0, A_TAB[k], B_TAB[k], O_TAB[k], F3_TAB[k], F7_TAB[k]);
            else       req_valid = '0;
            #1;
            if (k < 9) begin
                vecs++; if (req_ready !== 4'b0001) begin errs++; $display("FAIL op_gnt[%0d]: got %b want 0001", k, req_ready); end
            end
            if (k >= 2 && k < 11) begin
                vecs++; if (rsp_now() !== rsp(1'b1, 2'd0, R_TAB[k-2], R_TAB[k-2] == 32'd0)) begin errs++; $display("FAIL op_resp[%0d]: got %h want %h", k - 2, rsp_now(), rsp(1'b1, 2'd0, R_TAB[k-2], R_TAB[k-2] == 32'd0)); end
            end
            if (k == 11) begin
                vecs++; if (resp_valid !== 1'b0) begin errs++; $display("FAIL op_drain: resp_valid got %b want 0", resp_valid); end
            end
        end
    endtask

    task automatic test_reset_midflight();
        @(negedge clk);
        set_req(1, 32'd1, 32'd1, OPC_OP, F3_ADD, F7_BASE);
        set_req(2, 32'd2, 32'd2, OPC_OP, F3_ADD, F7_BASE);
        resp_ready = 1'b0;
        #1;
        vecs++; if (req_ready !== 4'b0010) begin errs++; $display("FAIL mid_gnt1: got %b want 0010", req_ready); end
        @(negedge clk);
        req_valid[1] = 1'b0;
        #1;
        vecs++; if (req_ready !== 4'b0100) begin errs++; $display("FAIL mid_gnt2: got %b want 0100", req_ready); end
        @(negedge clk);
        req_valid[2] = 1'b0;
        set_req(3, 32'd9, 32'd9, OPC_OP, F3_ADD, F7_BASE);
        #1;
        vecs++; if (rsp_now() !== rsp(1'b1, 2'd1, 32'd2, 1'b0)) begin errs++; $display("FAIL mid_full: got %h want %h", rsp_now(), rsp(1'b1, 2'd1, 32'd2, 1'b0)); end
        #1;
        rst_n = 1'b0;
        #1;
        vecs++; if (rsp_now() !== rsp(1'b0, 2'd0, 32'd0, 1'b0)) begin errs++; $display("FAIL mid_async: got %h want %h", rsp_now(), rsp(1'b0, 2'd0, 32'd0, 1'b0)); end
        vecs++; if (req_ready !== 4'b0000) begin errs++; $display("FAIL mid_ready_rst: got %b want 0000", req_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        resp_ready = 1'b1;
        set_req(0, 32'd4, 32'd4, OPC_OP, F3_ADD, F7_BASE);
        #1;
        vecs++; if (resp_valid !== 1'b0) begin errs++; $display("FAIL mid_stale0: resp_valid got %b want 0", resp_valid); end
        vecs++; if (req_ready !== 4'b0001) begin errs++; $display("FAIL mid_first: got %b want 0001", req_ready); end
        @(negedge clk);
        req_valid[0] = 1'b0;
        #1;
        vecs++; if (resp_valid !== 1'b0) begin errs++; $display("FAIL mid_stale1: resp_valid got %b want 0", resp_valid); end
        vecs++; if (req_ready !== 4'b1000) begin errs++; $display("FAIL mid_gnt3: got %b want 1000", req_ready); end
        @(negedge clk);
        req_valid = '0;
        #1;
        vecs++; if (rsp_now() !== rsp(1'b1, 2'd0, 32'd8, 1'b0)) begin errs++; $display("FAIL mid_resp0: got %h want %h", rsp_now(), rsp(1'b1, 2'd0, 32'd8, 1'b0)); end
        @(negedge clk); #1;
        vecs++; if (rsp_now() !== rsp(1'b1, 2'd3, 32'd18, 1'b0)) begin errs++; $display("FAIL mid_resp3: got %h want %h", rsp_now(), rsp(1'b1, 2'd3, 32'd18, 1'b0)); end
        @(negedge clk); #1;
        vecs++; if (resp_valid !== 1'b0) begin errs++; $display("FAIL mid_drain: resp_valid got %b want 0", resp_valid); end
    endtask

    task automatic test_wrap();
        @(negedge clk);
        set_req(3, 32'd7, 32'd8, OPC_OP, F3_ADD, F7_BASE);
        #1;
        vecs++; if (req_ready !== 4'b1000) begin errs++; $display("FAIL wrap_gnt3: got %b want 1000", req_ready); end
        @(negedge clk);
        set_req(0, 32'd100, 32'd1, OPC_OP, F3_ADD, F7_BASE);
        set_req(3, 32'd1, 32'd1, OPC_OP, F3_ADD, F7_BASE);
        #1;
        vecs++; if (req_ready !== 4'b0001) begin errs++; $display("FAIL wrap_gnt0: got %b want 0001", req_ready); end
        @(negedge clk);
        req_valid[0] = 1'b0;
        #1;
        vecs++; if (rsp_now() !== rsp(1'b1, 2'd3, 32'd15, 1'b0)) begin errs++; $display("FAIL wrap_resp3a: got %h want %h", rsp_now(), rsp(1'b1, 2'd3, 32'd15, 1'b0)); end
        vecs++; if (req_ready !== 4'b1000) begin errs++; $display("FAIL wrap_gnt3b: got %b want 1000", req_ready); end
        @(negedge clk);
        req_valid = '0;
        #1;
        vecs++; if (rsp_now() !== rsp(1'b1, 2'd0, 32'd101, 1'b0)) begin errs++; $display("FAIL wrap_resp0: got %h want %h", rsp_now(), rsp(1'b1, 2'd0, 32'd101, 1'b0)); end
        @(negedge clk); #1;
        vecs++; if (rsp_now() !== rsp(1'b1, 2'd3, 32'd2, 1'b0)) begin errs++; $display("FAIL wrap_resp3b: got %h want %h", rsp_now(), rsp(1'b1, 2'd3, 32'd2, 1'b0)); end
        @(negedge clk); #1;
        vecs++; if (resp_valid !== 1'b0) begin errs++; $display("FAIL wrap_drain: resp_valid got %b want 0", resp_valid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_sub();
        test_backpressure();
        test_unknown_opcode();
        test_alu_ops();
        test_reset_midflight();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one `alu` instance among NUM_CORES requesting cores through a two-stage pipeline: operand capture, then ALU evaluate with a result register. Each cycle it grants at most one requester, using round-robin order. It returns the result with the requester's ID over a single valid/ready response channel. It sits between the per-core decode stages and the shared execution resource.

## Interface
- NUM_CORES, default 4: number of requesters; must be ≥2.
- ID_W, default $clog2(NUM_CORES): width of the requester ID.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  NUM_CORES  per-core request valid.
- req_ready  out  NUM_CORES  one-hot grant; a handshake occurs when valid and ready are both high.
- req_op1  in  NUM_CORES×32  first operand for each core.
- req_op2  in  NUM_CORES×32  second operand for each core.
- req_opcode  in  NUM_CORES×7  opcode for each core.
- req_funct3  in  NUM_CORES×3  funct3 for each core.
- req_funct7  in  NUM_CORES×7  funct7 for each core.
- resp_valid  out  1  result register holds a valid result.
- resp_ready  in  1  consumer accepts the result.
- resp_id  out  ID_W  index of the core that issued the request.
- resp_result  out  32  ALU result.
- resp_zero  out  1  high when resp_result is 0.

## Operation
- S1 (capture) register fields: s1_valid, id, op1, op2, opcode, funct3, funct7.
- S2 (result) register fields: resp_valid, resp_id, resp_result, resp_zero.
- The ALU is combinational on the S1 fields.
- s2_free = !resp_valid | resp_ready.
- s1_free = !s1_valid | s2_free.
- Grant:
  - When s1_free is high, req_ready is one-hot on the first asserted req_valid, searching from rr_ptr upward with wrap-around.
  - When s1_free is low, req_ready is 0.
- On a grant to core g:
  - S1 loads core g's fields.
  - rr_ptr ← (g+1) mod NUM_CORES. For a non-power-of-2 NUM_CORES, the wrap goes explicitly to 0.
- With no grant, rr_ptr holds.
- When s1_valid and s2_free are both high, S2 loads the ALU outputs and the S1 id.
- s1_valid next value:
  - 1 if there is a grant this cycle.
  - Else 0 if S1 moved to S2.
  - Else it holds.
- resp_valid next value:
  - 1 when S2 loads.
  - Else 0 when resp_ready is high.
  - Else it holds.
- Stall: while resp_valid=1 and resp_ready=0, all S2 fields hold stable and S1 holds. No new grant is issued while S1 is full.
- Requester rules:
  - A core keeps its fields stable while req_valid=1 and req_ready=0.
  - A core must not derive req_valid from req_ready.
  - req_ready depends combinationally on req_valid, resp_valid and resp_ready.
- Unsupported opcode or funct combinations still complete. The result is 0 and resp_zero is 1.
- The alu `status` output is ignored.
- Reset, asynchronous at any time, including mid-operation:
  - s1_valid, resp_valid, resp_id, resp_result and rr_ptr go to 0.
  - resp_zero goes to 0.
  - In-flight requests are discarded and no response is produced for them.
  - req_ready is 0 while rst_n is low.

## Timing
- Latency: handshake at edge N puts S1 valid. With S2 free, resp_valid goes high after edge N+1 and is first visible in cycle N+1.
- Throughput: 1 request per cycle while resp_ready=1.
- Fairness: a continuously asserted req_valid is granted within NUM_CORES grant opportunities.
- All state updates on the rising edge of clk, apart from the asynchronous reset.

## Structure
- Package riscv_alu_pkg, shared with alu:
  - the OP, OP_IMM and funct constants;
  - a typedef struct alu_req_t {op1, op2, opcode, funct3, funct7}.
- The ports may be expressed as alu_req_t arrays.
- Sub-module rr_arbiter:
  - parameter N;
  - inputs: req[N], en, clk, rst_n;
  - outputs: gnt[N] one-hot, gnt_idx;
  - it owns rr_ptr.
- The existing alu is instantiated once.

## Test plan
- Single request, core 2: ADD with op1=5, op2=7, funct7=0, resp_ready=1 → one cycle after the grant, resp_valid=1, resp_id=2, resp_result=12, resp_zero=0.
- All 4 cores asserting SUB from reset, each with op1=op2=9 → grants in order 0,1,2,3,0 with rr_ptr tracking; responses back-to-back each cycle with resp_zero=1 and result 0.
- Backpressure: resp_ready held at 0 for 3 cycles with core1 SRA, op1=0x80000000, op2=4 → resp_result=0xF8000000 holds stable; S1 keeps the next request; req_ready stays 0; after release, both responses drain in order.
- Unknown opcode 7'h7F → resp_result=0, resp_zero=1, no hang.
- rst_n pulsed low with both stages full → outputs 0 immediately, no stale response after release, and the first grant goes to core 0.
- Core 3 only, after a core-3 grant → rr_ptr wraps to 0, and a later core-0 request is granted first.
